cmd_frame_ctrl: RTL and testbench

Parametrised UART command-frame controller sitting between the UART RX/TX parallel interfaces, the register file and the ALU. It decodes opcode-led frames: register write, register read, burst read, ALU with operands and ALU without operands. It drives register-file and ALU control and returns read data and multi-byte ALU results through the TX FIFO under backpressure. Compared with the single-byte controller, it adds inter-byte timeout, explicit frame-error reporting, burst read, and generic data/address/result widths.

---
 rtl/cmd_frame_ctrl_if.sv | 43 ++++
 rtl/cmd_frame_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_cmd_frame_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_frame_ctrl_if.sv
// cmd_frame_ctrl_if: bus bundle between the frame controller and the
// UART RX/TX, register file and ALU.
interface cmd_frame_ctrl_if #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int FUN_W     = 4,
   parameter int ALU_OUT_W = 16
);
   logic [DATA_W-1:0]    RX_P_DATA;
   logic                 RX_D_VLD;
   logic                 RX_ERR;
   logic [DATA_W-1:0]    RD_DATA;
   logic                 RD_DATA_VLD;
   logic [ALU_OUT_W-1:0] ALU_OUT;
   logic                 ALU_OUT_VLD;
   logic                 TX_FULL;
   logic [FUN_W-1:0]     ALU_FUN;
   logic                 ALU_EN;
   logic                 GATE_EN;
   logic [ADDR_W-1:0]    ADDR;
   logic                 WR_EN;
   logic                 RD_EN;
   logic [DATA_W-1:0]    WR_DATA;
   logic [DATA_W-1:0]    TX_P_DATA;
   logic                 TX_D_VLD;
   logic                 CLK_DIV_EN;
   logic                 FRAME_ERR;
   logic                 BUSY;

   modport master (
      input  RX_P_DATA, RX_D_VLD, RX_ERR, RD_DATA, RD_DATA_VLD,
      input  ALU_OUT, ALU_OUT_VLD, TX_FULL,
      output ALU_FUN, ALU_EN, GATE_EN, ADDR, WR_EN, RD_EN, WR_DATA,
      output TX_P_DATA, TX_D_VLD, CLK_DIV_EN, FRAME_ERR, BUSY
   );

   modport slave (
      output RX_P_DATA, RX_D_VLD, RX_ERR, RD_DATA, RD_DATA_VLD,
      output ALU_OUT, ALU_OUT_VLD, TX_FULL,
      input  ALU_FUN, ALU_EN, GATE_EN, ADDR, WR_EN, RD_EN, WR_DATA,
      input  TX_P_DATA, TX_D_VLD, CLK_DIV_EN, FRAME_ERR, BUSY
   );
endinterface

// File: rtl/cmd_frame_ctrl.sv
// cmd_frame_ctrl: opcode-led UART frame decoder driving the register
// file and ALU, returning read data / ALU results via the TX FIFO.
module cmd_frame_ctrl #(
   parameter int DATA_W      = 8,
   parameter int ADDR_W      = 4,
   parameter int FUN_W       = 4,
   parameter int ALU_OUT_W   = 16,
   parameter int TIMEOUT_CYC = 1023,
   parameter int OPA_ADDR    = 0,
   parameter int OPB_ADDR    = 1
) (
   input logic              CLK_IN,
   input logic              RST_IN,
   cmd_frame_ctrl_if.master bus
);
   localparam int NB    = ALU_OUT_W / DATA_W;
   localparam int NBW   = $clog2(NB + 1);
   localparam int CNT_W = (DATA_W > NBW) ? DATA_W : NBW;
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_WR_ADDR  = 4'd1;
   localparam logic [3:0] S_WR_DATA  = 4'd2;
   localparam logic [3:0] S_RD_ADDR  = 4'd3;
   localparam logic [3:0] S_BR_ADDR  = 4'd4;
   localparam logic [3:0] S_BR_CNT   = 4'd5;
   localparam logic [3:0] S_RD_REQ   = 4'd6;
   localparam logic [3:0] S_RD_WAIT  = 4'd7;
   localparam logic [3:0] S_OPA      = 4'd8;
   localparam logic [3:0] S_OPB      = 4'd9;
   localparam logic [3:0] S_FUN      = 4'd10;
   localparam logic [3:0] S_ALU_WAIT = 4'd11;
   localparam logic [3:0] S_TX_PUSH  = 4'd12;

   logic [3:0]           st_q, st_d;
   logic [TMR_W-1:0]     tmr_q, tmr_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [DATA_W-1:0]    wdat_q, wdat_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [ALU_OUT_W-1:0] sh_q, sh_d;
   logic                 alu_q, alu_d;
   logic [FUN_W-1:0]     fun_q, fun_d;
   logic [DATA_W-1:0]    txd_q, txd_d;
   logic wr_en_q, wr_en_d, rd_en_q, rd_en_d;
   logic alu_en_q, alu_en_d, gate_q, gate_d;
   logic txv_q, txv_d, ferr_q, ferr_d, busy_q, busy_d;

   logic       rx_ok, rx_bad, rx_st, tmo, abort;
   logic [7:0] op;

   // Frame sequencing, timeout supervision and output next-state
   always_comb begin
      rx_ok  = bus.RX_D_VLD & ~bus.RX_ERR;
      rx_bad = bus.RX_D_VLD & bus.RX_ERR;
      op     = bus.RX_P_DATA[7:0];
      tmo    = (tmr_q == TMR_W'(TIMEOUT_CYC));
      rx_st  = st_q inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_BR_ADDR,
                            S_BR_CNT, S_OPA, S_OPB, S_FUN};
      abort  = (rx_st && (rx_bad || (!rx_ok && tmo)))
             || (st_q == S_RD_WAIT && !bus.RD_DATA_VLD && tmo)
             || (st_q == S_ALU_WAIT && !bus.ALU_OUT_VLD && tmo);

      st_d     = st_q;
      addr_d   = addr_q;
      wdat_d   = wdat_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      alu_d    = alu_q;
      fun_d    = fun_q;
      txd_d    = txd_q;
      gate_d   = gate_q;
      wr_en_d  = 1'b0;
      rd_en_d  = 1'b0;
      alu_en_d = 1'b0;
      txv_d    = 1'b0;
      ferr_d   = 1'b0;

      if (abort) begin
         st_d   = S_IDLE;
         ferr_d = 1'b1;
         gate_d = 1'b0;
      end else begin
         case (st_q)
            S_IDLE: if (rx_ok) begin
               unique case (1'b1)
                  (op == 8'hAA): st_d = S_WR_ADDR;
                  (op == 8'hBB): st_d = S_RD_ADDR;
                  (op == 8'hEE): st_d = S_BR_ADDR;
                  (op == 8'hCC): begin st_d = S_OPA; gate_d = 1'b1; end
                  (op == 8'hDD): begin st_d = S_FUN; gate_d = 1'b1; end
                  default: ;
               endcase
            end
            S_WR_ADDR: if (rx_ok) begin
               addr_d = bus.RX_P_DATA[ADDR_W-1:0];
               st_d   = S_WR_DATA;
            end
            S_WR_DATA: if (rx_ok) begin
               wdat_d  = bus.RX_P_DATA;
               wr_en_d = 1'b1;
               st_d    = S_IDLE;
            end
            S_RD_ADDR: if (rx_ok) begin
               addr_d = bus.RX_P_DATA[ADDR_W-1:0];
               cnt_d  = CNT_W'(1);
               st_d   = S_RD_REQ;
            end
            S_BR_ADDR: if (rx_ok) begin
               addr_d = bus.RX_P_DATA[ADDR_W-1:0];
               st_d   = S_BR_CNT;
            end
            S_BR_CNT: if (rx_ok) begin
               cnt_d = CNT_W'(bus.RX_P_DATA);
               st_d  = (bus.RX_P_DATA == '0) ? S_IDLE : S_RD_REQ;
            end
            S_RD_REQ: begin
               rd_en_d = 1'b1;
               st_d    = S_RD_WAIT;
            end
            S_RD_WAIT: if (bus.RD_DATA_VLD) begin
               sh_d  = ALU_OUT_W'(bus.RD_DATA);
               alu_d = 1'b0;
               st_d  = S_TX_PUSH;
            end
            S_OPA: if (rx_ok) begin
               addr_d  = ADDR_W'(OPA_ADDR);
               wdat_d  = bus.RX_P_DATA;
               wr_en_d = 1'b1;
               st_d    = S_OPB;
            end
            S_OPB: if (rx_ok) begin
               addr_d  = ADDR_W'(OPB_ADDR);
               wdat_d  = bus.RX_P_DATA;
               wr_en_d = 1'b1;
               st_d    = S_FUN;
            end
            S_FUN: if (rx_ok) begin
               fun_d    = bus.RX_P_DATA[FUN_W-1:0];
               alu_en_d = 1'b1;
               st_d     = S_ALU_WAIT;
            end
            S_ALU_WAIT: if (bus.ALU_OUT_VLD) begin
               sh_d   = bus.ALU_OUT;
               cnt_d  = CNT_W'(NB);
               alu_d  = 1'b1;
               gate_d = 1'b0;
               st_d   = S_TX_PUSH;
            end
            S_TX_PUSH: if (!bus.TX_FULL) begin
               txv_d = 1'b1;
               txd_d = sh_q[DATA_W-1:0];
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  st_d = S_IDLE;
               end else if (alu_q) begin
                  sh_d = sh_q >> DATA_W;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  st_d   = S_RD_REQ;
               end
            end
            default: st_d = S_IDLE;
         endcase
      end

      tmr_d  = ((st_d != st_q) || (rx_ok && rx_st)) ? '0
             : tmr_q + TMR_W'(1);
      busy_d = (st_d != S_IDLE);
   end

   // State and registered outputs
   always_ff @(posedge CLK_IN or negedge RST_IN) begin
      if (!RST_IN) begin
         st_q     <= S_IDLE;
         tmr_q    <= '0;
         addr_q   <= '0;
         wdat_q   <= '0;
         cnt_q    <= '0;
         sh_q     <= '0;
         alu_q    <= 1'b0;
         fun_q    <= '0;
         txd_q    <= '0;
         gate_q   <= 1'b0;
         wr_en_q  <= 1'b0;
         rd_en_q  <= 1'b0;
         alu_en_q <= 1'b0;
         txv_q    <= 1'b0;
         ferr_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         st_q     <= st_d;
         tmr_q    <= tmr_d;
         addr_q   <= addr_d;
         wdat_q   <= wdat_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
         alu_q    <= alu_d;
         fun_q    <= fun_d;
         txd_q    <= txd_d;
         gate_q   <= gate_d;
         wr_en_q  <= wr_en_d;
         rd_en_q  <= rd_en_d;
         alu_en_q <= alu_en_d;
         txv_q    <= txv_d;
         ferr_q   <= ferr_d;
         busy_q   <= busy_d;
      end
   end

   assign bus.ALU_FUN    = fun_q;
   assign bus.ALU_EN     = alu_en_q;
   assign bus.GATE_EN    = gate_q;
   assign bus.ADDR       = addr_q;
   assign bus.WR_EN      = wr_en_q;
   assign bus.RD_EN      = rd_en_q;
   assign bus.WR_DATA    = wdat_q;
   assign bus.TX_P_DATA  = txd_q;
   assign bus.TX_D_VLD   = txv_q;
   assign bus.CLK_DIV_EN = 1'b1;
   assign bus.FRAME_ERR  = ferr_q;
   assign bus.BUSY       = busy_q;
endmodule

// File: tb/tb_cmd_frame_ctrl.sv
// tb_cmd_frame_ctrl: frame-level bench with register-file / ALU / TX FIFO
// responders and a transaction-level expectation model.
module tb_cmd_frame_ctrl;
   localparam int T = 40;

   logic clk;
   logic rst_n;
   cmd_frame_ctrl_if bus ();

   cmd_frame_ctrl #(.TIMEOUT_CYC(T)) dut (
      .CLK_IN (clk),
      .RST_IN (rst_n),
      .bus    (bus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int vec = 0;
   int miss = 0;
   int fe_cnt = 0;
   int exp_fe = 0;
   int full_viol = 0;
   int gate_viol = 0;
   logic force_full = 1'b0;
   logic rand_full = 1'b0;
   logic alu_hold = 1'b0;

   logic [7:0]  regs [16];
   logic [7:0]  mregs [16];
   logic [11:0] obs_wr[$], exp_wr[$];
   logic [3:0]  obs_rd[$], exp_rd[$];
   logic [7:0]  obs_tx[$], exp_tx[$];
   logic [3:0]  obs_fun[$], exp_fun[$];

   function automatic logic [15:0] alu(input logic [7:0] a,
                                       input logic [7:0] b,
                                       input logic [3:0] f);
      case (f[1:0])
         2'd0: return 16'(a) + 16'(b);
         2'd1: return 16'(a) - 16'(b);
         2'd2: return 16'(a) * 16'(b);
         default: return {a, b};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] o,
                      input logic [31:0] e);
      vec++;
      assert (o === e) else begin
         miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
   endtask

   // Register file, ALU and TX FIFO stand-ins plus output monitor
   initial begin
      int rd_cd, alu_cd;
      logic [7:0]  rd_val;
      logic [15:0] alu_val;
      rd_cd = -1;
      alu_cd = -1;
      rd_val = '0;
      alu_val = '0;
      for (int i = 0; i < 16; i++) regs[i] = '0;
      bus.RD_DATA = '0;
      bus.RD_DATA_VLD = 1'b0;
      bus.ALU_OUT = '0;
      bus.ALU_OUT_VLD = 1'b0;
      bus.TX_FULL = 1'b0;
      forever begin
         @(negedge clk);
         bus.RD_DATA_VLD = 1'b0;
         bus.ALU_OUT_VLD = 1'b0;
         if (!rst_n) begin
            rd_cd = -1;
            alu_cd = -1;
         end else begin
            if (bus.TX_D_VLD) begin
               obs_tx.push_back(bus.TX_P_DATA);
               if (bus.TX_FULL) full_viol++;
            end
            if (bus.FRAME_ERR) fe_cnt++;
            if (bus.ALU_EN && !bus.GATE_EN) gate_viol++;
            if (bus.WR_EN) begin
               obs_wr.push_back({bus.ADDR, bus.WR_DATA});
               regs[bus.ADDR] = bus.WR_DATA;
            end
            if (rd_cd == 0) begin
               bus.RD_DATA = rd_val;
               bus.RD_DATA_VLD = 1'b1;
               rd_cd = -1;
            end else if (rd_cd > 0) rd_cd--;
            if (bus.RD_EN) begin
               obs_rd.push_back(bus.ADDR);
               rd_val = regs[bus.ADDR];
               rd_cd = int'($urandom_range(0, 3));
            end
            if (alu_hold) alu_cd = -1;
            else if (alu_cd == 0) begin
               bus.ALU_OUT = alu_val;
               bus.ALU_OUT_VLD = 1'b1;
               alu_cd = -1;
            end else if (alu_cd > 0) alu_cd--;
            if (bus.ALU_EN) begin
               obs_fun.push_back(bus.ALU_FUN);
               alu_val = alu(regs[0], regs[1], bus.ALU_FUN);
               if (!alu_hold) alu_cd = int'($urandom_range(0, 3));
            end
         end
         bus.TX_FULL = force_full |
                       (rand_full && ($urandom_range(0, 3) == 0));
      end
   end

   task automatic send(input logic [7:0] b, input logic err = 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      bus.RX_P_DATA = b;
      bus.RX_D_VLD = 1'b1;
      bus.RX_ERR = err;
      @(negedge clk);
      bus.RX_D_VLD = 1'b0;
      bus.RX_ERR = 1'b0;
   endtask

   task automatic m_wr(input logic [7:0] a, input logic [7:0] d);
      exp_wr.push_back({a[3:0], d});
      mregs[a[3:0]] = d;
   endtask

   task automatic m_rd(input logic [7:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         int ad;
         ad = (int'(a[3:0]) + i) % 16;
         exp_rd.push_back(4'(ad));
         exp_tx.push_back(mregs[ad]);
      end
   endtask

   task automatic m_alu(input logic [7:0] f);
      logic [15:0] r;
      r = alu(mregs[0], mregs[1], f[3:0]);
      exp_fun.push_back(f[3:0]);
      for (int i = 0; i < 2; i++) exp_tx.push_back(8'(r >> (8 * i)));
   endtask

   task automatic fr_wr(input logic [7:0] a, input logic [7:0] d);
      send(8'hAA); send(a); send(d);
      m_wr(a, d);
   endtask

   task automatic fr_rd(input logic [7:0] a);
      send(8'hBB); send(a);
      m_rd(a, 1);
   endtask

   task automatic fr_br(input logic [7:0] a, input logic [7:0] n);
      send(8'hEE); send(a); send(n);
      m_rd(a, int'(n));
   endtask

   task automatic fr_cc(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] f);
      send(8'hCC); send(x); send(y); send(f);
      m_wr(8'h00, x); m_wr(8'h01, y); m_alu(f);
   endtask

   task automatic fr_dd(input logic [7:0] f);
      send(8'hDD); send(f);
      m_alu(f);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.BUSY !== 1'b0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " idle"}, 32'(n < 2000), 32'd1);
      repeat (6) @(negedge clk);
   endtask

   task automatic cmp_frame(input string tag);
      chk({tag, " nwr"}, 32'(obs_wr.size()), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++)
         chk({tag, " wr"}, 32'(obs_wr[i]), 32'(exp_wr[i]));
      chk({tag, " nrd"}, 32'(obs_rd.size()), 32'(exp_rd.size()));
      for (int i = 0; i < exp_rd.size() && i < obs_rd.size(); i++)
         chk({tag, " rd"}, 32'(obs_rd[i]), 32'(exp_rd[i]));
      chk({tag, " ntx"}, 32'(obs_tx.size()), 32'(exp_tx.size()));
      for (int i = 0; i < exp_tx.size() && i < obs_tx.size(); i++)
         chk({tag, " tx"}, 32'(obs_tx[i]), 32'(exp_tx[i]));
      chk({tag, " nfun"}, 32'(obs_fun.size()), 32'(exp_fun.size()));
      for (int i = 0; i < exp_fun.size() && i < obs_fun.size(); i++)
         chk({tag, " fun"}, 32'(obs_fun[i]), 32'(exp_fun[i]));
      chk({tag, " ferr"}, 32'(fe_cnt), 32'(exp_fe));
      obs_wr.delete(); exp_wr.delete();
      obs_rd.delete(); exp_rd.delete();
      obs_tx.delete(); exp_tx.delete();
      obs_fun.delete(); exp_fun.delete();
      fe_cnt = 0;
      exp_fe = 0;
   endtask

   task automatic wait_ferr(input string tag, input int lo, input int hi);
      int n;
      n = 0;
      while (bus.FRAME_ERR !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({tag, " ferr win"}, 32'(n >= lo && n <= hi), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mregs[i] = '0;
      bus.RX_P_DATA = '0;
      bus.RX_D_VLD = 1'b0;
      bus.RX_ERR = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst outs", 32'({bus.ALU_FUN, bus.ALU_EN, bus.GATE_EN, bus.ADDR,
                           bus.WR_EN, bus.RD_EN, bus.WR_DATA, bus.TX_P_DATA,
                           bus.TX_D_VLD, bus.FRAME_ERR, bus.BUSY}), 32'd0);
      chk("rst clkdiv", 32'(bus.CLK_DIV_EN), 32'd1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // write frame
      fr_wr(8'h05, 8'h3C);
      chk("wr pulse", 32'({bus.WR_EN, bus.ADDR, bus.WR_DATA}), 32'h153C);
      chk("wr busy", 32'(bus.BUSY), 32'd0);
      @(negedge clk);
      chk("wr 1cyc", 32'(bus.WR_EN), 32'd0);
      wait_idle("wr");
      cmp_frame("wr");

      // bad byte and unknown opcode in IDLE are ignored
      send(8'hAA, 1'b1);
      chk("idle err busy", 32'(bus.BUSY), 32'd0);
      send(8'h55);
      chk("idle junk busy", 32'(bus.BUSY), 32'd0);
      wait_idle("junk");
      cmp_frame("junk");

      // single read
      fr_wr(8'h07, 8'h9A);
      fr_rd(8'h07);
      wait_idle("rd");
      cmp_frame("rd");

      // burst read with address wrap
      fr_wr(8'h0E, 8'h11);
      fr_wr(8'h0F, 8'h22);
      fr_wr(8'h00, 8'h33);
      fr_br(8'h0E, 8'h03);
      wait_idle("burst");
      cmp_frame("burst");

      // ALU with operands, gate check
      send(8'hCC);
      chk("gate rise", 32'(bus.GATE_EN), 32'd1);
      send(8'h10); send(8'h03); send(8'h00);
      m_wr(8'h00, 8'h10); m_wr(8'h01, 8'h03); m_alu(8'h00);
      chk("add model", 32'({exp_tx[0], exp_tx[1]}), 32'h1300);
      wait_idle("alu");
      chk("gate fall", 32'(bus.GATE_EN), 32'd0);
      cmp_frame("alu");

      // ALU with TX FIFO full longer than the timeout
      force_full = 1'b1;
      fr_cc(8'h10, 8'h03, 8'h00);
      repeat (60) @(negedge clk);
      chk("full hold ntx", 32'(obs_tx.size()), 32'd0);
      chk("full hold busy", 32'(bus.BUSY), 32'd1);
      force_full = 1'b0;
      wait_idle("alufull");
      cmp_frame("alufull");

      // inter-byte timeout then recovery
      send(8'hAA); send(8'h05);
      wait_ferr("to", T, T + 2);
      @(negedge clk);
      chk("to 1cyc", 32'({bus.FRAME_ERR, bus.BUSY}), 32'd0);
      exp_fe = 1;
      cmp_frame("to");
      fr_wr(8'h01, 8'hFF);
      wait_idle("to rec");
      cmp_frame("to rec");

      // RX error mid ALU frame
      send(8'hCC); send(8'h10); send(8'h33, 1'b1);
      chk("rxerr ferr", 32'(bus.FRAME_ERR), 32'd1);
      chk("rxerr gate", 32'(bus.GATE_EN), 32'd0);
      m_wr(8'h00, 8'h10);
      exp_fe = 1;
      wait_idle("rxerr");
      cmp_frame("rxerr");

      // ALU never answers
      alu_hold = 1'b1;
      send(8'hDD); send(8'h01);
      exp_fun.push_back(4'h1);
      wait_ferr("alu to", T - 2, T + 3);
      @(negedge clk);
      chk("alu to gate", 32'(bus.GATE_EN), 32'd0);
      exp_fe = 1;
      wait_idle("alu to");
      cmp_frame("alu to");

      // reset during ALU_WAIT
      send(8'hCC); send(8'h21); send(8'h05); send(8'h02);
      m_wr(8'h00, 8'h21); m_wr(8'h01, 8'h05);
      exp_fun.push_back(4'h2);
      repeat (3) @(negedge clk);
      chk("pre rst busy", 32'({bus.BUSY, bus.GATE_EN}), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("mid rst outs", 32'({bus.ALU_FUN, bus.ALU_EN, bus.GATE_EN,
                               bus.ADDR, bus.WR_EN, bus.RD_EN, bus.WR_DATA,
                               bus.TX_P_DATA, bus.TX_D_VLD, bus.FRAME_ERR,
                               bus.BUSY}), 32'd0);
      chk("mid rst clkdiv", 32'(bus.CLK_DIV_EN), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      alu_hold = 1'b0;
      repeat (4) @(negedge clk);
      cmp_frame("rst");

      // randomized frames with random FIFO backpressure
      rand_full = 1'b1;
      for (int f = 0; f < 40; f++) begin
         logic [7:0] a, d, x, fn;
         logic [7:0] junk [4];
         junk[0] = 8'h00; junk[1] = 8'h55;
         junk[2] = 8'hFF; junk[3] = 8'hA5;
         a = 8'($urandom);
         d = 8'($urandom);
         x = 8'($urandom);
         fn = 8'($urandom_range(0, 15));
         if ($urandom_range(0, 4) == 0) send(junk[$urandom_range(0, 3)]);
         case ($urandom_range(0, 4))
            0: fr_wr(a, d);
            1: fr_rd(a);
            2: fr_br(a, 8'($urandom_range(0, 5)));
            3: fr_cc(d, x, fn);
            default: fr_dd(fn);
         endcase
         wait_idle("rand");
         cmp_frame("rand");
      end
      rand_full = 1'b0;

      chk("push while full", 32'(full_viol), 32'd0);
      chk("alu_en w/o gate", 32'(gate_viol), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule
